// File: rtl/jk_ff.sv
// Bank of WIDTH independent JK flip-flops, updating on the falling clock edge,
// with an asynchronous active-low clear that loads RST_VAL into every bit.
module jk_ff #(
  parameter int unsigned WIDTH   = 1,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             R,
  input  logic             Cp,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = Q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({J[i], K[i]})
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        2'b11:   q_d[i] = ~Q[i];
        default: q_d[i] = Q[i];
      endcase
    end
  end

  // Reset also wins when R and Cp fall together: the R=0 branch is taken either way.
  always_ff @(negedge Cp or negedge R) begin
    if (!R) begin
      Q <= {WIDTH{RST_VAL}};
    end else begin
      Q <= q_d;
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_jk_ff.sv
// Scoreboarded bench for jk_ff: a 4-bit bank (RST_VAL=0) and a 1-bit cell (RST_VAL=1)
// share R/Cp; every R or Cp transition queues the expected state for the monitor.
module tb_jk_ff;

  logic       cp = 1'b1;
  logic       r  = 1'b1;
  logic [3:0] j  = 4'h0;
  logic [3:0] k  = 4'h0;
  logic [3:0] q, qn;
  logic       q1, qn1;

  jk_ff #(.WIDTH(4), .RST_VAL(1'b0)) u_dut (
    .J(j), .K(k), .R(r), .Cp(cp), .Q(q), .Qn(qn)
  );

  jk_ff #(.WIDTH(1), .RST_VAL(1'b1)) u_dut1 (
    .J(j[0]), .K(k[0]), .R(r), .Cp(cp), .Q(q1), .Qn(qn1)
  );

  typedef struct {
    logic [3:0] q;
    logic       q1;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] m_q;
  logic       m_q1;
  string      cur_tag = "init";

  // Reference behaviour written from the JK truth table, one bit at a time.
  function automatic logic [3:0] jk_next(input logic [3:0] cur, input logic [3:0] jj,
                                         input logic [3:0] kk);
    logic [3:0] nxt;
    for (int i = 0; i < 4; i++) begin
      if (jj[i] && kk[i])  nxt[i] = !cur[i];
      else if (jj[i])      nxt[i] = 1'b1;
      else if (kk[i])      nxt[i] = 1'b0;
      else                 nxt[i] = cur[i];
    end
    return nxt;
  endfunction

  // Apply new R/Cp levels together; queue one expectation per observable transition.
  task automatic step(input logic nr, input logic ncp);
    exp_t e;
    logic [3:0] n1;
    if (nr == r && ncp == cp) begin
      #5;
      return;
    end
    if (!nr) begin
      m_q  = 4'h0;
      m_q1 = 1'b1;
    end else if (r && cp && !ncp) begin
      n1   = jk_next({3'b000, m_q1}, j, k);
      m_q  = jk_next(m_q, j, k);
      m_q1 = n1[0];
    end
    e.q   = m_q;
    e.q1  = m_q1;
    e.tag = cur_tag;
    exp_q.push_back(e);
    r  = nr;
    cp = ncp;
    #5;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge cp or negedge cp or posedge r or negedge r);
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: q=%h q1=%b seen with nothing expected", q, q1);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (q !== e.q || q1 !== e.q1) begin
          bad++;
          $display("FAIL %s q: got q=%h q1=%b, want q=%h q1=%b", e.tag, q, q1, e.q, e.q1);
        end
        total++;
        if (qn !== ~e.q || qn1 !== ~e.q1) begin
          bad++;
          $display("FAIL %s qn: got qn=%h qn1=%b, want qn=%h qn1=%b",
                   e.tag, qn, qn1, ~e.q, ~e.q1);
        end
      end
    end
  end

  initial begin : driver
    int waited;
    logic [3:0] cnt;
    #2;

    cur_tag = "reset_hold";
    j = 4'hf; k = 4'hf;
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, ~cp);

    cur_tag = "reset_release";
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    cur_tag = "set_then_hold";
    j = 4'hf; k = 4'h0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    j = 4'h0; k = 4'h0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    cur_tag = "clear_rise_ignored";
    j = 4'h0; k = 4'hf;
    step(1'b1, 1'b0);
    j = 4'hf; k = 4'h0;
    step(1'b1, 1'b1);

    cur_tag = "toggle_seq";
    j = 4'hf; k = 4'hf;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
    end

    cur_tag = "mixed_bits";
    j = 4'b1010; k = 4'b0110;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    cur_tag = "async_clear_mid";
    j = 4'hf; k = 4'h0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    cur_tag = "simul_fall";
    j = 4'hf; k = 4'h0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    cur_tag = "sweep";
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = c[3:0];
        j = {4{cnt[3]}};
        k = {4{cnt[2]}};
        step(cnt[1], cp);
        step(cnt[1], cnt[0]);
      end
    end
    step(1'b1, 1'b1);

    cur_tag = "random";
    repeat (300) begin
      j = 4'($urandom);
      k = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        step(1'b0, cp);
        step(1'b1, cp);
      end else begin
        step(1'b1, 1'b0);
        j = 4'($urandom);
        k = 4'($urandom);
        step(1'b1, 1'b1);
      end
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
